// File: rtl/taillight_pkg.sv
// Shared types and bit positions for the tail-light input front end.
package taillight_pkg;

  // Lighting mode codes consumed by the blink sequencer and LED mapper
  typedef enum logic [2:0] {
    MODE_IDLE        = 3'd0,
    MODE_LEFT        = 3'd1,
    MODE_RIGHT       = 3'd2,
    MODE_LEFT_BRAKE  = 3'd3,
    MODE_RIGHT_BRAKE = 3'd4,
    MODE_BRAKE       = 3'd5,
    MODE_HAZARD      = 3'd6,
    MODE_RESET       = 3'd7
  } mode_t;

  // Switch bit positions (active-high)
  localparam int unsigned SW_HAZARD = 0;
  localparam int unsigned SW_TURN   = 1;
  localparam int unsigned SW_BRAKE  = 2;

  // Key bit positions (active-low)
  localparam int unsigned KEY_RST = 0;
  localparam int unsigned KEY_DIR = 1;

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a hold-time debounce counter for one input bit.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after it holds for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= RESET_VAL;
      s2    <= RESET_VAL;
      clean <= RESET_VAL;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/taillight_input_conditioner.sv
// Debounces switches/keys and decodes them into one registered lighting mode.
module taillight_input_conditioner
  import taillight_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] sw_raw,
  input  logic [1:0] key_raw,
  output logic [2:0] mode,
  output logic       mode_change,
  output logic [2:0] clean_sw,
  output logic [1:0] clean_key
);

  mode_t mode_q;
  mode_t mode_dec;
  logic  h, t, b, r, q;

  // Switches rest low, keys rest high (released)
  for (genvar i = 0; i < 3; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (sw_raw[i]),
      .clean(clean_sw[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (key_raw[i]),
      .clean(clean_key[i])
    );
  end

  assign h = clean_sw[SW_HAZARD];
  assign t = clean_sw[SW_TURN];
  assign b = clean_sw[SW_BRAKE];
  assign r = ~clean_key[KEY_DIR];
  assign q = ~clean_key[KEY_RST];

  // Priority decode of the clean levels; first matching rule wins
  always_comb begin
    mode_dec = MODE_IDLE;
    if (q && (h || t || b)) begin
      mode_dec = MODE_RESET;
    end else if (!h && !t && !b) begin
      mode_dec = MODE_IDLE;
    end else if (t && !h && !b) begin
      mode_dec = r ? MODE_RIGHT : MODE_LEFT;
    end else if (t && !h && b) begin
      mode_dec = r ? MODE_RIGHT_BRAKE : MODE_LEFT_BRAKE;
    end else if (b) begin
      mode_dec = MODE_BRAKE;
    end else begin
      mode_dec = MODE_HAZARD;
    end
  end

  // Register the mode and flag the first cycle of every new value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_IDLE;
      mode_change <= 1'b0;
    end else begin
      mode_q      <= mode_dec;
      mode_change <= (mode_dec != mode_q);
    end
  end

  assign mode = 3'(mode_q);

endmodule

// File: tb/tb_taillight_input_conditioner.sv
// Self-checking bench: directed scenarios plus random holds against a window-based reference model.
module tb_taillight_input_conditioner;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw_raw = 3'b000;
  logic [1:0] key_raw = 2'b11;
  logic [2:0] mode;
  logic       mode_change;
  logic [2:0] clean_sw;
  logic [1:0] clean_key;

  int total = 0;
  int bad   = 0;

  // Reference state: raw samples per edge ({key,sw}), clean levels, mode, pulse
  logic [4:0] hist[$];
  logic [4:0] m_clean;
  logic [2:0] m_mode;
  logic       m_chg;

  taillight_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .key_raw    (key_raw),
    .mode       (mode),
    .mode_change(mode_change),
    .clean_sw   (clean_sw),
    .clean_key  (clean_key)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] ref_decode(input logic [4:0] c);
    logic h, t, b, r, q;
    h = c[0]; t = c[1]; b = c[2]; r = ~c[4]; q = ~c[3];
    if (q && (h || t || b)) return 3'd7;
    if (!h && !t && !b)     return 3'd0;
    if (t && !h && !b)      return r ? 3'd2 : 3'd1;
    if (t && !h && b)       return r ? 3'd4 : 3'd3;
    if (b)                  return 3'd5;
    return 3'd6;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back(5'b11000);
    m_clean = 5'b11000;
    m_mode  = 3'd0;
    m_chg   = 1'b0;
  endtask

  // A bit flips once the last D synchronised samples (raw delayed two edges) all disagree with it
  task automatic model_edge();
    logic [2:0] dec;
    logic [4:0] nc;
    logic [4:0] smp;
    logic       flip;
    dec    = ref_decode(m_clean);
    m_chg  = (dec != m_mode);
    m_mode = dec;
    hist.push_back({key_raw, sw_raw});
    nc = m_clean;
    for (int bi = 0; bi < 5; bi++) begin
      flip = 1'b1;
      for (int m = 1; m <= D; m++) begin
        smp = hist[m];
        if (smp[bi] == m_clean[bi]) flip = 1'b0;
      end
      if (flip) nc[bi] = ~m_clean[bi];
    end
    void'(hist.pop_front());
    m_clean = nc;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_mode", 4'(mode), 4'(m_mode));
    chk("model_mode_change", 4'(mode_change), 4'(m_chg));
    chk("model_clean_sw", 4'(clean_sw), 4'(m_clean[2:0]));
    chk("model_clean_key", 4'(clean_key), 4'(m_clean[4:3]));
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      cycle();
      if (mode_change) pulses++;
    end
  endtask

  initial begin
    int p;
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    chk("reset_mode", 4'(mode), 4'd0);
    chk("reset_clean_key", 4'(clean_key), 4'd3);
    run(10, p);
    chk("reset_release_no_pulse", 4'(p), 4'd0);

    // Clean step latency
    sw_raw = 3'b010;
    repeat (5) cycle();
    chk("step_clean_edge4", 4'(clean_sw), 4'b0000);
    cycle();
    chk("step_clean_edge5", 4'(clean_sw), 4'b0010);
    cycle();
    chk("step_mode_edge6", 4'(mode), 4'd1);
    chk("step_pulse_edge6", 4'(mode_change), 4'd1);
    cycle();
    chk("step_pulse_edge7", 4'(mode_change), 4'd0);

    // Glitch rejection, then a held brake
    sw_raw = 3'b000;
    run(10, p);
    chk("back_idle", 4'(mode), 4'd0);
    sw_raw = 3'b100;
    repeat (3) cycle();
    sw_raw = 3'b000;
    run(12, p);
    chk("glitch_no_pulse", 4'(p), 4'd0);
    chk("glitch_mode", 4'(mode), 4'd0);
    chk("glitch_clean", 4'(clean_sw), 4'd0);
    sw_raw = 3'b100;
    repeat (6) cycle();
    chk("brake_edge5_mode", 4'(mode), 4'd0);
    cycle();
    chk("brake_edge6_mode", 4'(mode), 4'd5);
    chk("brake_edge6_pulse", 4'(mode_change), 4'd1);
    sw_raw = 3'b000;
    run(10, p);

    // Direction and brake
    sw_raw = 3'b010; key_raw = 2'b01;
    run(10, p);
    chk("dir_right", 4'(mode), 4'd2);
    chk("dir_right_pulses", 4'(p), 4'd1);
    sw_raw = 3'b110;
    run(10, p);
    chk("dir_right_brake", 4'(mode), 4'd4);
    chk("dir_right_brake_pulses", 4'(p), 4'd1);
    key_raw = 2'b11;
    run(10, p);
    chk("dir_left_brake", 4'(mode), 4'd3);
    chk("dir_left_brake_pulses", 4'(p), 4'd1);

    // Priority chain
    sw_raw = 3'b111;
    run(10, p);
    chk("prio_all_brake", 4'(mode), 4'd5);
    chk("prio_all_pulses", 4'(p), 4'd1);
    sw_raw = 3'b011;
    run(10, p);
    chk("prio_hazard", 4'(mode), 4'd6);
    chk("prio_hazard_pulses", 4'(p), 4'd1);
    key_raw = 2'b10;
    run(10, p);
    chk("prio_reset", 4'(mode), 4'd7);
    chk("prio_reset_pulses", 4'(p), 4'd1);
    sw_raw = 3'b000;
    run(10, p);
    chk("prio_q_idle", 4'(mode), 4'd0);
    chk("prio_q_idle_pulses", 4'(p), 4'd1);
    key_raw = 2'b11;
    run(10, p);
    chk("q_release_no_pulse", 4'(p), 4'd0);

    // Simultaneous settle of two bits
    sw_raw = 3'b101;
    run(10, p);
    chk("simul_mode", 4'(mode), 4'd5);
    chk("simul_single_pulse", 4'(p), 4'd1);

    // Random holds, including sub-threshold glitches
    repeat (120) begin
      sw_raw  = 3'($urandom_range(0, 7));
      key_raw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 7)) cycle();
    end

    // Reset mid-count
    sw_raw = 3'b000; key_raw = 2'b11;
    run(10, p);
    sw_raw = 3'b011;
    repeat (4) cycle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_mode", 4'(mode), 4'd0);
    chk("async_reset_pulse", 4'(mode_change), 4'd0);
    chk("async_reset_clean_sw", 4'(clean_sw), 4'd0);
    chk("async_reset_clean_key", 4'(clean_key), 4'd3);
    cycle();
    reset = 1'b0;
    repeat (6) cycle();
    chk("redebounce_edge5_mode", 4'(mode), 4'd0);
    cycle();
    chk("redebounce_edge6_mode", 4'(mode), 4'd6);
    chk("redebounce_edge6_pulse", 4'(mode_change), 4'd1);
    run(5, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
